// File: rtl/parallel_serializer_pkg.sv
// rtl/parallel_serializer_pkg.sv - shared state type and defaults for the parallel serializer
package parallel_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - bit position counter with clear, increment and last-bit flag
module ser_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over increment so a word boundary always restarts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/parallel_serializer.sv
// rtl/parallel_serializer.sv - loads a parallel word and shifts it out one bit per shift_enable
module parallel_serializer
    import parallel_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_enable,
    output logic             data,
    output logic             busy,
    output logic             done
);

    ser_state_e       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_shifted;
    logic             data_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic             cnt_last;
    logic             accept;
    logic             shift_now;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign accept    = (state_q == ST_IDLE) && load_valid && ready_q;
    assign shift_now = (state_q == ST_SHIFT) && shift_enable;

    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};

    // The counter restarts on acceptance and after the final bit, so it never wraps.
    ser_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (accept || (shift_now && cnt_last)),
        .inc_i   (shift_now && !cnt_last),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_SHIFT;
                        shreg_q <= load_data;
                        data_q  <= head_bit(load_data);
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_enable) begin
                        if (cnt_last) begin
                            state_q <= ST_IDLE;
                            shreg_q <= '0;
                            data_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            shreg_q <= shreg_shifted;
                            data_q  <= head_bit(shreg_shifted);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data       = data_q;

endmodule

// File: tb/tb_parallel_serializer.sv
// tb/tb_parallel_serializer.sv - directed self-checking bench for parallel_serializer
module tb_parallel_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ready;
    logic       m_shift = 1'b0;
    logic       m_dout;
    logic       m_busy;
    logic       m_done;

    logic [7:0] l_data = 8'h00;
    logic       l_valid = 1'b0;
    logic       l_ready;
    logic       l_shift = 1'b0;
    logic       l_dout;
    logic       l_busy;
    logic       l_done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rx;
    logic [15:0] rx16;

    always #5 clk = ~clk;

    parallel_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk          (clk),
        .reset        (reset),
        .load_data    (m_data),
        .load_valid   (m_valid),
        .load_ready   (m_ready),
        .shift_enable (m_shift),
        .data         (m_dout),
        .busy         (m_busy),
        .done         (m_done)
    );

    parallel_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .load_data    (l_data),
        .load_valid   (l_valid),
        .load_ready   (l_ready),
        .shift_enable (l_shift),
        .data         (l_dout),
        .busy         (l_busy),
        .done         (l_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift a loaded word out of dut_m, optionally stalling before bit index stall_at.
    task automatic shift_word_m(input logic [7:0] w, input int stall_at, input int stall_len,
                                output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                m_shift = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("stall_hold", {15'd0, m_dout}, {15'd0, w[7-i]});
                    chk("stall_busy", {15'd0, m_busy}, 16'd1);
                end
            end
            m_shift = 1'b1;
            chk("m_bit", {15'd0, m_dout}, {15'd0, w[7-i]});
            chk("m_no_early_done", {15'd0, m_done}, 16'd0);
            r = {r[6:0], m_dout};
            step();
        end
        m_shift = 1'b0;
        chk("m_done_pulse", {15'd0, m_done}, 16'd1);
        chk("m_idle_data", {15'd0, m_dout}, 16'd0);
        chk("m_idle_busy", {15'd0, m_busy}, 16'd0);
        chk("m_idle_ready", {15'd0, m_ready}, 16'd1);
    endtask

    task automatic load_m(input logic [7:0] w);
        m_data  = w;
        m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        chk("m_load_busy", {15'd0, m_busy}, 16'd1);
        chk("m_load_ready", {15'd0, m_ready}, 16'd0);
    endtask

    initial begin
        // Reset held with load and shift requests active.
        reset   = 1'b0;
        m_valid = 1'b1;
        m_data  = 8'hFF;
        m_shift = 1'b1;
        step();
        step();
        chk("rst_data", {15'd0, m_dout}, 16'd0);
        chk("rst_busy", {15'd0, m_busy}, 16'd0);
        chk("rst_done", {15'd0, m_done}, 16'd0);
        chk("rst_ready", {15'd0, m_ready}, 16'd1);
        m_valid = 1'b0;
        reset   = 1'b1;

        // shift_enable in idle does nothing.
        repeat (3) step();
        chk("idle_shift_data", {15'd0, m_dout}, 16'd0);
        chk("idle_shift_busy", {15'd0, m_busy}, 16'd0);
        chk("idle_shift_done", {15'd0, m_done}, 16'd0);
        m_shift = 1'b0;

        // Basic A5, MSB first, with loopback.
        load_m(8'hA5);
        shift_word_m(8'hA5, -1, 0, rx);
        chk("basic_loopback", {8'd0, rx}, 16'h00A5);
        step();
        chk("basic_done_one_cycle", {15'd0, m_done}, 16'd0);

        // Stall after bit 2.
        load_m(8'h3C);
        shift_word_m(8'h3C, 3, 3, rx);
        chk("stall_loopback", {8'd0, rx}, 16'h003C);
        step();

        // Loads while busy are ignored; the held request lands on the done cycle.
        load_m(8'h96);
        m_data  = 8'hFF;
        m_valid = 1'b1;
        shift_word_m(8'h96, -1, 0, rx);
        chk("ignored_load_word", {8'd0, rx}, 16'h0096);
        step();
        m_valid = 1'b0;
        m_data  = 8'h00;
        chk("next_load_on_done_busy", {15'd0, m_busy}, 16'd1);
        chk("next_load_on_done_done", {15'd0, m_done}, 16'd0);
        shift_word_m(8'hFF, -1, 0, rx);
        chk("next_load_word", {8'd0, rx}, 16'h00FF);
        step();

        // Abort 8'hF0 after 4 bits.
        load_m(8'hF0);
        m_shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_bit", {15'd0, m_dout}, 16'd1);
            step();
        end
        m_shift = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", {15'd0, m_busy}, 16'd0);
        chk("abort_data", {15'd0, m_dout}, 16'd0);
        chk("abort_done", {15'd0, m_done}, 16'd0);
        chk("abort_ready", {15'd0, m_ready}, 16'd1);
        step();
        chk("abort_no_late_done", {15'd0, m_done}, 16'd0);
        load_m(8'h01);
        shift_word_m(8'h01, -1, 0, rx);
        chk("after_abort_word", {8'd0, rx}, 16'h0001);
        step();

        // Back-to-back LSB first: 81 then 7E loaded on the done cycle.
        l_data  = 8'h81;
        l_valid = 1'b1;
        step();
        l_valid = 1'b0;
        l_shift = 1'b1;
        rx16 = 16'h0000;
        rx = 8'h81;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_bit_w0", {15'd0, l_dout}, {15'd0, rx[i]});
            rx16 = {l_dout, rx16[15:1]};
            step();
        end
        chk("b2b_done", {15'd0, l_done}, 16'd1);
        chk("b2b_ready_on_done", {15'd0, l_ready}, 16'd1);
        l_data  = 8'h7E;
        l_valid = 1'b1;
        step();
        l_valid = 1'b0;
        chk("b2b_reload_busy", {15'd0, l_busy}, 16'd1);
        rx = 8'h7E;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_bit_w1", {15'd0, l_dout}, {15'd0, rx[i]});
            rx16 = {l_dout, rx16[15:1]};
            step();
        end
        l_shift = 1'b0;
        chk("b2b_done2", {15'd0, l_done}, 16'd1);
        chk("b2b_stream", rx16, 16'h7E81);
        step();
        chk("b2b_done2_cleared", {15'd0, l_done}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
